// File: rtl/bist_controller_mc.sv
// -----------------------------------------------------------------------------
// bist_controller_mc
//
// Purpose:
//   Multi-channel BIST sequencer. A start request launches NCH test sessions
//   back to back. Each session is one INIT cycle, NCLOCK RUN cycles with a
//   divided toggle stimulus, and one FINISH cycle. After the last session the
//   controller parks in DONE with bist_end held high until the next start or
//   reset. ch_sel selects the per-channel pattern generator / compactor of
//   the session in progress.
//
// Optional feature:
//   BIST_ABORT_EN - when defined, adds the abort input and aborted output.
//   abort sampled high in INIT/RUN/FINISH terminates the run into DONE with
//   aborted set and ch_sel frozen at the interrupted session.
//
// Handshake:
//   start is a level sampled on every rising clk edge; it is acted on only in
//   IDLE or DONE and is otherwise dropped (no queueing). There is no
//   back-pressure: the outputs are pure status/strobe signals.
//
// Ports:
//   clk        in   1     system clock, rising edge
//   reset_n    in   1     asynchronous active-low reset
//   start      in   1     BIST request (level)
//   abort      in   1     abort request          (BIST_ABORT_EN only)
//   init       out  1     one-cycle pulse at the start of each session
//   running    out  1     high for NCLOCK cycles per session
//   toggle     out  1     stimulus square wave, only while running
//   finish     out  1     one-cycle pulse at the end of each session
//   bist_end   out  1     high from completion until next start or reset
//   ch_sel     out  CH_W  current session index 0..NCH-1
//   aborted    out  1     run ended by abort      (BIST_ABORT_EN only)
//   dbg_state  out  3     FSM state register, for debug and checkers
//
// reset_n deassertion is expected to be synchronised to clk upstream.
// -----------------------------------------------------------------------------
module bist_controller_mc #(
    parameter  int NCLOCK     = 650,
    parameter  int NCH        = 2,
    parameter  int TOGGLE_DIV = 1,
    localparam int CNT_W      = $clog2(NCLOCK + 1),
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int DIV_W      = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
`ifdef BIST_ABORT_EN
    input  logic            abort,
`endif
    output logic            init,
    output logic            running,
    output logic            toggle,
    output logic            finish,
    output logic            bist_end,
    output logic [CH_W-1:0] ch_sel,
`ifdef BIST_ABORT_EN
    output logic            aborted,
`endif
    output logic [2:0]      dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_RUN    = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic              toggle_q, toggle_d;
    logic [CH_W-1:0]   ch_q,    ch_d;
    logic              aborted_q, aborted_d;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            toggle_q  <= 1'b0;
            ch_q      <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            toggle_q  <= toggle_d;
            ch_q      <= ch_d;
            aborted_q <= aborted_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        toggle_d  = 1'b0;           // toggle is low in every state except RUN
        ch_d      = ch_q;
        aborted_d = aborted_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_INIT;
                    ch_d      = '0;
                    aborted_d = 1'b0;
                end
            end
            S_INIT: begin
                // Counter and divider restart for every session.
                cnt_d   = '0;
                div_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // cnt_q holds the number of running cycles already completed,
                // so the cycle where it equals NCLOCK-1 is the last one.
                cnt_d = cnt_q + 1'b1;
                if (div_q == DIV_W'(TOGGLE_DIV - 1)) begin
                    div_d    = '0;
                    toggle_d = ~toggle_q;
                end else begin
                    div_d    = div_q + 1'b1;
                    toggle_d = toggle_q;
                end
                if (cnt_q == CNT_W'(NCLOCK - 1)) begin
                    state_d  = S_FINISH;
                    toggle_d = 1'b0;
                end
            end
            S_FINISH: begin
                if (ch_q == CH_W'(NCH - 1)) begin
                    state_d = S_DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_INIT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef BIST_ABORT_EN
        // Abort only matters while a run is active; in IDLE/DONE start wins.
        if (abort && (state_q == S_INIT || state_q == S_RUN ||
                      state_q == S_FINISH)) begin
            state_d   = S_DONE;
            toggle_d  = 1'b0;
            ch_d      = ch_q;
            aborted_d = 1'b1;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Moore outputs decoded from registered state
    // -------------------------------------------------------------------------
    assign init      = (state_q == S_INIT);
    assign running   = (state_q == S_RUN);
    assign finish    = (state_q == S_FINISH);
    assign bist_end  = (state_q == S_DONE);
    assign toggle    = toggle_q;
    assign ch_sel    = ch_q;
    assign dbg_state = state_q;
`ifdef BIST_ABORT_EN
    assign aborted   = aborted_q;
`endif

endmodule

// File: tb/tb_bist_controller_mc.sv
// -----------------------------------------------------------------------------
// tb_bist_controller_mc
//
// Two instances share one clock:
//   dut A : NCLOCK=650, NCH=2, TOGGLE_DIV=1
//   dut B : NCLOCK=20,  NCH=3, TOGGLE_DIV=5
// The driver pushes time-stamped expected events (init / finish pulses and
// the bist_end rising edge) into a per-instance queue before it issues a
// start. The monitor samples on the falling edge, turns every observed event
// into the same packed form and pops/compares. An event's time stamp is the
// index of the rising edge at which the event value is sampled, so a start
// sampled at edge E0 gives its first init at E0+1.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bist_controller_mc;

    localparam int W = 25;  // {kind[1:0], ch[1:0], aborted, time[19:0]}
    localparam logic [1:0] K_INIT = 2'd0;
    localparam logic [1:0] K_FIN  = 2'd1;
    localparam logic [1:0] K_END  = 2'd2;

    // ---------------------------------------------------------------------
    // Clock / reset
    // ---------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a_n, start_a, rst_b_n, start_b;
    logic init_a, running_a, toggle_a, finish_a, bist_end_a, aborted_a;
    logic init_b, running_b, toggle_b, finish_b, bist_end_b, aborted_b;
    logic [0:0] ch_sel_a;
    logic [1:0] ch_sel_b;
    logic [2:0] dbg_state_a, dbg_state_b;
`ifdef BIST_ABORT_EN
    logic abort_a, abort_b;
`else
    assign aborted_a = 1'b0;
    assign aborted_b = 1'b0;
`endif

    bist_controller_mc #(.NCLOCK(650), .NCH(2), .TOGGLE_DIV(1)) u_dut_a (
        .clk       (clk),
        .reset_n   (rst_a_n),
        .start     (start_a),
`ifdef BIST_ABORT_EN
        .abort     (abort_a),
`endif
        .init      (init_a),
        .running   (running_a),
        .toggle    (toggle_a),
        .finish    (finish_a),
        .bist_end  (bist_end_a),
        .ch_sel    (ch_sel_a),
`ifdef BIST_ABORT_EN
        .aborted   (aborted_a),
`endif
        .dbg_state (dbg_state_a)
    );

    bist_controller_mc #(.NCLOCK(20), .NCH(3), .TOGGLE_DIV(5)) u_dut_b (
        .clk       (clk),
        .reset_n   (rst_b_n),
        .start     (start_b),
`ifdef BIST_ABORT_EN
        .abort     (abort_b),
`endif
        .init      (init_b),
        .running   (running_b),
        .toggle    (toggle_b),
        .finish    (finish_b),
        .bist_end  (bist_end_b),
        .ch_sel    (ch_sel_b),
`ifdef BIST_ABORT_EN
        .aborted   (aborted_b),
`endif
        .dbg_state (dbg_state_b)
    );

    // ---------------------------------------------------------------------
    // Scoreboard state
    // ---------------------------------------------------------------------
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    int unsigned  checks = 0;
    int unsigned  passed = 0;
    int unsigned  run_cnt[2];
    int unsigned  rise_cnt[2];
    int unsigned  stray_tog[2];
    logic         prev_tog[2];
    logic         prev_end[2];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    endtask

    task automatic ev_check(input int d, input logic [W-1:0] got);
        logic [W-1:0] exp;
        checks++;
        if ((d == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0)) begin
            $display("FAIL event dut%0d: got kind=%0d ch=%0d ab=%0d t=%0d, none expected",
                     d, got[24:23], got[22:21], got[20], got[19:0]);
        end else begin
            exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (got == exp) passed++;
            else $display("FAIL event dut%0d: got kind=%0d ch=%0d ab=%0d t=%0d expected kind=%0d ch=%0d ab=%0d t=%0d",
                          d, got[24:23], got[22:21], got[20], got[19:0],
                          exp[24:23], exp[22:21], exp[20], exp[19:0]);
        end
    endtask

    // ---------------------------------------------------------------------
    // Monitor
    // ---------------------------------------------------------------------
    task automatic observe(input int d, input logic i_v, input logic f_v,
                           input logic e_v, input logic r_v, input logic t_v,
                           input logic a_v, input logic [1:0] ch);
        logic [19:0] ts;
        ts = 20'(cyc + 1);
        if (i_v === 1'b1) ev_check(d, {K_INIT, ch, 1'b0, ts});
        if (f_v === 1'b1) ev_check(d, {K_FIN, ch, 1'b0, ts});
        if (e_v === 1'b1 && prev_end[d] !== 1'b1) ev_check(d, {K_END, ch, a_v, ts});
        prev_end[d] = e_v;
        if (r_v === 1'b1) run_cnt[d]++;
        if (t_v === 1'b1 && prev_tog[d] !== 1'b1) rise_cnt[d]++;
        if (t_v === 1'b1 && r_v !== 1'b1) stray_tog[d]++;
        prev_tog[d] = t_v;
    endtask

    always @(negedge clk) begin
        observe(0, init_a, finish_a, bist_end_a, running_a, toggle_a, aborted_a,
                {1'b0, ch_sel_a});
        observe(1, init_b, finish_b, bist_end_b, running_b, toggle_b, aborted_b,
                ch_sel_b);
    end

    // ---------------------------------------------------------------------
    // Driver tasks
    // ---------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic clr(input int d);
        run_cnt[d]   = 0;
        rise_cnt[d]  = 0;
        stray_tog[d] = 0;
    endtask

    task automatic push_ev(input int d, input logic [1:0] k, input logic [1:0] ch,
                           input logic ab, input int unsigned t);
        logic [W-1:0] e;
        e = {k, ch, ab, 20'(t)};
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    // Full run: session k has init at E0+1+k*(nclk+2), finish nclk+1 later;
    // end_off is the hand-computed bist_end offset from E0.
    task automatic push_run(input int d, input int unsigned e0, input int nclk,
                            input int nch, input int unsigned end_off);
        for (int k = 0; k < nch; k++) begin
            push_ev(d, K_INIT, 2'(k), 1'b0, e0 + 1 + k * (nclk + 2));
            push_ev(d, K_FIN,  2'(k), 1'b0, e0 + nclk + 2 + k * (nclk + 2));
        end
        push_ev(d, K_END, 2'(nch - 1), 1'b0, e0 + end_off);
    endtask

    task automatic start_run_a(output int unsigned e0);
        start_a = 1'b1;
        e0 = cyc + 1;
        push_run(0, e0, 650, 2, 1305);
        tick();
        start_a = 1'b0;
    endtask

    task automatic wait_end(input int d, input int budget, input string name);
        int n;
        n = 0;
        while (((d == 0) ? bist_end_a : bist_end_b) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({name, " bist_end reached"}, (d == 0) ? bist_end_a : bist_end_b, 1);
    endtask

    task automatic wait_run(input int d, input int unsigned target, input int budget,
                            input string name);
        int n;
        n = 0;
        while (run_cnt[d] < target && n < budget) begin
            tick();
            n++;
        end
        chk({name, " running cycles reached"}, run_cnt[d], target);
    endtask

    task automatic check_counts(input int d, input int unsigned runs,
                                input int unsigned rises, input string name);
        chk({name, " running cycles"}, run_cnt[d], runs);
        chk({name, " toggle rising edges"}, rise_cnt[d], rises);
        chk({name, " toggle outside running"}, stray_tog[d], 0);
    endtask

    // ---------------------------------------------------------------------
    // Watchdog
    // ---------------------------------------------------------------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far",
                 passed, checks);
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        int unsigned e0;
        for (int d = 0; d < 2; d++) begin
            prev_tog[d] = 1'b0;
            prev_end[d] = 1'b0;
            clr(d);
        end
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
`ifdef BIST_ABORT_EN
        abort_a = 1'b0;
        abort_b = 1'b0;
`endif
        #1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("reset outputs A", {26'd0, init_a, running_a, toggle_a, finish_a,
                                bist_end_a, aborted_a}, 0);
        chk("reset ch_sel A", ch_sel_a, 0);
        chk("reset state A", dbg_state_a, 0);
        chk("reset outputs B", {26'd0, init_b, running_b, toggle_b, finish_b,
                                bist_end_b, aborted_b}, 0);
        chk("reset ch_sel B", ch_sel_b, 0);
        // start and reset together: reset wins
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("start during reset A", dbg_state_a, 0);
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        repeat (2) tick();
        clr(0);

        // Normal run
        start_run_a(e0);
        wait_end(0, 1400, "normal");
        tick();
        check_counts(0, 1300, 650, "normal");
        chk("normal ch_sel", ch_sel_a, 1);
        chk("normal running low", running_a, 0);
        chk("normal bist_end held", bist_end_a, 1);

        // Restart from DONE, with a second start 3 cycles into RUN
        clr(0);
        start_run_a(e0);
        chk("restart bist_end dropped", bist_end_a, 0);
        wait_run(0, 3, 10, "midstart");
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_end(0, 1400, "midstart");
        tick();
        check_counts(0, 1300, 650, "midstart");

        // Complete run, reset 2 cycles, new run with identical counts
        rst_a_n = 1'b0;
        tick();
        chk("reset clears bist_end", bist_end_a, 0);
        tick();
        rst_a_n = 1'b1;
        tick();
        clr(0);
        start_run_a(e0);
        wait_end(0, 1400, "after reset");
        tick();
        check_counts(0, 1300, 650, "after reset");

        // Reset in running cycle 5
        clr(0);
        start_run_a(e0);
        wait_run(0, 5, 10, "midreset");
        rst_a_n = 1'b0;
        #1;
        chk("midreset outputs", {26'd0, init_a, running_a, toggle_a, finish_a,
                                 bist_end_a, aborted_a}, 0);
        chk("midreset ch_sel", ch_sel_a, 0);
        exp_q0.delete();
        tick();
        tick();
        rst_a_n = 1'b1;
        repeat (10) tick();
        chk("midreset stays idle", dbg_state_a, 0);
        chk("midreset running cycles", run_cnt[0], 5);

        // Divided toggle, three sessions
        clr(1);
        start_b = 1'b1;
        e0 = cyc + 1;
        push_run(1, e0, 20, 3, 67);
        tick();
        start_b = 1'b0;
        wait_end(1, 100, "div5");
        tick();
        check_counts(1, 60, 6, "div5");
        chk("div5 ch_sel", ch_sel_b, 2);
        chk("div5 state DONE", dbg_state_b, 4);

`ifdef BIST_ABORT_EN
        // Abort in running cycle 100 of session 1
        clr(0);
        start_a = 1'b1;
        e0 = cyc + 1;
        push_ev(0, K_INIT, 2'd0, 1'b0, e0 + 1);
        push_ev(0, K_FIN,  2'd0, 1'b0, e0 + 652);
        push_ev(0, K_INIT, 2'd1, 1'b0, e0 + 653);
        push_ev(0, K_END,  2'd1, 1'b1, e0 + 754);
        tick();
        start_a = 1'b0;
        wait_run(0, 750, 800, "abort");
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort aborted", aborted_a, 1);
        chk("abort bist_end", bist_end_a, 1);
        chk("abort ch_sel", ch_sel_a, 1);
        chk("abort running/toggle", {30'd0, running_a, toggle_a}, 0);
        tick();
        check_counts(0, 750, 375, "abort");
        // abort ignored in DONE
        abort_a = 1'b1;
        repeat (2) tick();
        chk("abort in DONE ignored", dbg_state_a, 4);
        // start beats abort in DONE and clears aborted
        start_a = 1'b1;
        push_ev(0, K_INIT, 2'd0, 1'b0, cyc + 2);
        tick();
        start_a = 1'b0;
        abort_a = 1'b0;
        chk("restart clears aborted", aborted_a, 0);
        chk("restart init", init_a, 1);
        rst_a_n = 1'b0;
        tick();
        rst_a_n = 1'b1;
`endif

        repeat (3) tick();
        chk("queue A drained", exp_q0.size(), 0);
        chk("queue B drained", exp_q1.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
